// File: rtl/ring_stat_accum.sv
// Star-ring statistics: accumulates per-pixel sum / sum-of-squares on the Chebyshev ring
// around a tracked centroid over 2^LOG2_FRAMES frames, then emits mean and variance.
module ring_stat_accum #(
    parameter int PIX_W       = 8,
    parameter int COORD_W     = 10,
    parameter int WIDTH       = 1024,
    parameter int HEIGHT      = 1024,
    parameter int HALF        = 3,
    parameter int LOG2_FRAMES = 3,
    parameter int IDX_W       = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           vs,
    input  logic                           pix_valid,
    input  logic [PIX_W-1:0]               din,
    input  logic                           star_valid,
    input  logic [COORD_W-1:0]             star_x,
    input  logic [COORD_W-1:0]             star_y,
    input  logic                           rd_en,
    input  logic [IDX_W-1:0]               rd_addr,
    output logic [2*COORD_W+3*PIX_W-1:0]   rd_data,
    output logic                           res_valid,
    input  logic                           res_ack,
    output logic                           frame_drop,
    output logic                           overrun,
    output logic                           busy
);

    localparam int RING_N = 8 * HALF;
    localparam int DEPTH  = 2 ** IDX_W;
    localparam int FRAMES = 2 ** LOG2_FRAMES;
    localparam int SUM_W  = PIX_W + LOG2_FRAMES;
    localparam int SQ_W   = 2 * PIX_W + LOG2_FRAMES;
    localparam int RES_W  = 2 * COORD_W + 3 * PIX_W;
    localparam int CNT_W  = LOG2_FRAMES + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, COMPUTE} state_t;

    state_t               state_q;
    logic                 vs_q;
    logic [COORD_W-1:0]   row_q, col_q;
    logic [COORD_W-1:0]   pos_x_q, pos_y_q;
    logic                 pos_valid_q;
    logic                 frame_ok_q;
    logic [IDX_W:0]       hit_q;
    logic [CNT_W-1:0]     count_q;
    logic [IDX_W-1:0]     cidx_q;
    logic                 cdrop_q;
    logic                 res_valid_q, frame_drop_q, overrun_q, busy_q;
    logic [RES_W-1:0]     rd_data_q;

    logic [SUM_W-1:0]         sum_q [DEPTH];
    logic [SQ_W-1:0]          sq_q  [DEPTH];
    logic [2*COORD_W-1:0]     rc_q  [DEPTH];
    logic [RES_W-1:0]         res_q [DEPTH];

    logic                 vs_rise, collecting, on_ring, hit, last_pix, frame_end;
    logic                 ring_full, batch_last, go_compute, compute_last, in_compute_d;
    logic signed [COORD_W:0] dr, dc;
    logic [COORD_W:0]     adr, adc;
    logic [IDX_W:0]       hits_d;
    logic [2*PIX_W-1:0]   dsq_d;
    logic [PIX_W-1:0]     mean_d;
    logic [2*PIX_W-1:0]   msq_d, m2_d, var_d;

    assign vs_rise    = vs & ~vs_q;
    assign collecting = frame_ok_q && (state_q != COMPUTE);

    always_comb begin
        dr      = $signed({1'b0, row_q}) - $signed({1'b0, pos_x_q});
        dc      = $signed({1'b0, col_q}) - $signed({1'b0, pos_y_q});
        adr     = dr[COORD_W] ? (~dr + 1'b1) : dr;
        adc     = dc[COORD_W] ? (~dc + 1'b1) : dc;
        on_ring = ((adr == (COORD_W+1)'(HALF)) && (adc <= (COORD_W+1)'(HALF))) ||
                  ((adc == (COORD_W+1)'(HALF)) && (adr <= (COORD_W+1)'(HALF)));
    end

    assign hit          = pix_valid && collecting && on_ring && (hit_q < (IDX_W+1)'(RING_N));
    assign last_pix     = pix_valid && (row_q == COORD_W'(HEIGHT-1)) && (col_q == COORD_W'(WIDTH-1));
    assign frame_end    = last_pix && collecting;
    assign hits_d       = hit_q + (IDX_W+1)'(hit);
    assign ring_full    = (hits_d == (IDX_W+1)'(RING_N));
    assign batch_last   = (count_q == CNT_W'(FRAMES-1));
    assign go_compute   = (state_q != COMPUTE) && frame_end && ring_full && batch_last && !res_valid_q;
    assign compute_last = (state_q == COMPUTE) && (cidx_q == IDX_W'(RING_N-1));
    // A vs arriving while COMPUTE runs (or starts this cycle) only re-latches the star.
    assign in_compute_d = ((state_q == COMPUTE) && !compute_last) || go_compute;

    assign dsq_d = {{PIX_W{1'b0}}, din} * {{PIX_W{1'b0}}, din};

    always_comb begin
        mean_d = PIX_W'(sum_q[cidx_q] >> LOG2_FRAMES);
        msq_d  = (2*PIX_W)'(sq_q[cidx_q] >> LOG2_FRAMES);
        m2_d   = {{PIX_W{1'b0}}, mean_d} * {{PIX_W{1'b0}}, mean_d};
        var_d  = (msq_d >= m2_d) ? (msq_d - m2_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sum_q[i] <= '0;
                sq_q[i]  <= '0;
                rc_q[i]  <= '0;
                res_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else if (enable) begin
            if (hit) begin
                if (count_q == '0) begin
                    sum_q[hit_q[IDX_W-1:0]] <= SUM_W'(din);
                    sq_q[hit_q[IDX_W-1:0]]  <= SQ_W'(dsq_d);
                    rc_q[hit_q[IDX_W-1:0]]  <= {row_q, col_q};
                end else begin
                    sum_q[hit_q[IDX_W-1:0]] <= sum_q[hit_q[IDX_W-1:0]] + SUM_W'(din);
                    sq_q[hit_q[IDX_W-1:0]]  <= sq_q[hit_q[IDX_W-1:0]] + SQ_W'(dsq_d);
                end
            end
            if (state_q == COMPUTE) begin
                res_q[cidx_q] <= {rc_q[cidx_q], mean_d, var_d};
            end
            if (rd_en && res_valid_q) begin
                rd_data_q <= res_q[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            vs_q         <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            pos_valid_q  <= 1'b0;
            frame_ok_q   <= 1'b0;
            hit_q        <= '0;
            count_q      <= '0;
            cidx_q       <= '0;
            cdrop_q      <= 1'b0;
            res_valid_q  <= 1'b0;
            frame_drop_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else if (enable) begin
            vs_q         <= vs;
            frame_drop_q <= 1'b0;
            overrun_q    <= 1'b0;
            if (res_ack && res_valid_q) res_valid_q <= 1'b0;

            if (pix_valid) begin
                if (col_q == COORD_W'(WIDTH-1)) begin
                    col_q <= '0;
                    row_q <= (row_q == COORD_W'(HEIGHT-1)) ? '0 : row_q + COORD_W'(1);
                end else begin
                    col_q <= col_q + COORD_W'(1);
                end
            end
            if (hit) hit_q <= hit_q + (IDX_W+1)'(1);

            case (state_q)
                COMPUTE: begin
                    if (pix_valid) begin
                        frame_ok_q <= 1'b0;
                        cdrop_q    <= 1'b1;
                        if (!cdrop_q) frame_drop_q <= 1'b1;
                    end
                    cidx_q <= cidx_q + IDX_W'(1);
                    if (compute_last) begin
                        state_q     <= pos_valid_q ? ACCUM : IDLE;
                        busy_q      <= 1'b0;
                        res_valid_q <= 1'b1;
                    end
                end
                default: begin
                    if (frame_end) begin
                        frame_ok_q <= 1'b0;
                        if (!ring_full) begin
                            frame_drop_q <= 1'b1;
                            count_q      <= '0;
                        end else if (batch_last) begin
                            count_q <= '0;
                            if (res_valid_q) begin
                                overrun_q <= 1'b1;
                            end else begin
                                state_q <= COMPUTE;
                                busy_q  <= 1'b1;
                                cidx_q  <= '0;
                                cdrop_q <= 1'b0;
                            end
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
            endcase

            // Placed last so frame-end bookkeeping above resolves before the new frame starts.
            if (vs_rise) begin
                row_q <= '0;
                col_q <= '0;
                hit_q <= '0;
                if (!star_valid) begin
                    pos_valid_q <= 1'b0;
                    frame_ok_q  <= 1'b0;
                    count_q     <= '0;
                    if (!in_compute_d) state_q <= IDLE;
                end else begin
                    frame_ok_q <= 1'b1;
                    if (!pos_valid_q || (star_x != pos_x_q) || (star_y != pos_y_q)) begin
                        pos_x_q     <= star_x;
                        pos_y_q     <= star_y;
                        pos_valid_q <= 1'b1;
                        count_q     <= '0;
                        if (!in_compute_d) state_q <= ACCUM;
                    end
                end
            end
        end
    end

    assign rd_data    = rd_data_q;
    assign res_valid  = res_valid_q;
    assign frame_drop = frame_drop_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ring_stat_accum.sv
// Scoreboard bench for ring_stat_accum: a behavioural ring model pushes expected entries,
// which are popped and compared as the result buffer is read back.
module tb_ring_stat_accum;

    localparam int PIX_W   = 8;
    localparam int COORD_W = 10;
    localparam int W       = 16;
    localparam int H       = 16;
    localparam int HALF    = 2;
    localparam int L2F     = 2;
    localparam int IDX_W   = 5;
    localparam int RING_N  = 8 * HALF;
    localparam int RES_W   = 2 * COORD_W + 3 * PIX_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b1;
    logic               vs = 1'b0;
    logic               pix_valid = 1'b0;
    logic [PIX_W-1:0]   din = '0;
    logic               star_valid = 1'b0;
    logic [COORD_W-1:0] star_x = '0;
    logic [COORD_W-1:0] star_y = '0;
    logic               rd_en = 1'b0;
    logic [IDX_W-1:0]   rd_addr = '0;
    logic [RES_W-1:0]   rd_data;
    logic               res_valid;
    logic               res_ack = 1'b0;
    logic               frame_drop, overrun, busy;

    ring_stat_accum #(
        .PIX_W(PIX_W), .COORD_W(COORD_W), .WIDTH(W), .HEIGHT(H),
        .HALF(HALF), .LOG2_FRAMES(L2F), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .vs(vs), .pix_valid(pix_valid),
        .din(din), .star_valid(star_valid), .star_x(star_x), .star_y(star_y),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .res_valid(res_valid),
        .res_ack(res_ack), .frame_drop(frame_drop), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int n_drop = 0;
    int n_ovr = 0;
    int n_busy = 0;

    logic [RES_W-1:0] exp_q[$];
    logic [RES_W-1:0] last_exp = '0;
    int               m_sum [RING_N];
    int               m_sq  [RING_N];
    logic [19:0]      m_rc  [RING_N];

    always @(negedge clk) begin
        if (frame_drop) n_drop++;
        if (overrun)    n_ovr++;
        if (busy)       n_busy++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int f, input int r, input int c);
        case (pat)
            0:       return 8'd100;
            1:       return (f % 2 == 1) ? 8'd20 : 8'd10;
            default: return 8'((r * 13 + c * 7 + f * 29 + pat * 11) & 255);
        endcase
    endfunction

    task automatic drive_frame(input int sx, input int sy, input int pat, input int f, input bit first);
        int k;
        int ar, ac;
        logic [7:0] v;
        k = 0;
        @(negedge clk);
        star_x = COORD_W'(sx);
        star_y = COORD_W'(sy);
        star_valid = 1'b1;
        vs = 1'b1;
        @(negedge clk);
        vs = 1'b0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                v = pix(pat, f, r, c);
                pix_valid = 1'b1;
                din = v;
                ar = (r > sx) ? r - sx : sx - r;
                ac = (c > sy) ? c - sy : sy - c;
                if (((ar == HALF && ac <= HALF) || (ac == HALF && ar <= HALF)) && k < RING_N) begin
                    if (first) begin
                        m_sum[k] = int'(v);
                        m_sq[k]  = int'(v) * int'(v);
                    end else begin
                        m_sum[k] += int'(v);
                        m_sq[k]  += int'(v) * int'(v);
                    end
                    m_rc[k] = {10'(r), 10'(c)};
                    k++;
                end
                @(negedge clk);
            end
        end
        pix_valid = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic push_expected();
        int mean, msq, vr;
        for (int k = 0; k < RING_N; k++) begin
            mean = m_sum[k] >> L2F;
            msq  = m_sq[k] >> L2F;
            vr   = (msq >= mean * mean) ? msq - mean * mean : 0;
            exp_q.push_back({m_rc[k], 8'(mean), 16'(vr)});
        end
    endtask

    task automatic read_one(input int addr, output logic [RES_W-1:0] data);
        @(negedge clk);
        rd_en = 1'b1;
        rd_addr = IDX_W'(addr);
        @(posedge clk);
        #1;
        data = rd_data;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic read_check(input string tag);
        logic [RES_W-1:0] d;
        for (int k = 0; k < RING_N; k++) begin
            read_one(k, d);
            if (exp_q.size() == 0) begin
                chk($sformatf("%s_underflow[%0d]", tag, k), 64'd1, 64'd0);
            end else begin
                last_exp = exp_q.pop_front();
                chk($sformatf("%s[%0d]", tag, k), d, last_exp);
            end
        end
    endtask

    task automatic wait_res(input string tag);
        int t;
        t = 0;
        while (!res_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_res_valid"}, res_valid, 1);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        chk({tag, "_ack_clears"}, res_valid, 0);
    endtask

    initial begin
        int d0, o0, b0;
        logic [RES_W-1:0] d;

        repeat (3) @(negedge clk);
        chk("reset_outs", {res_valid, frame_drop, overrun, busy, rd_data}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: constant din over a full batch
        b0 = n_busy;
        for (int f = 0; f < 4; f++) drive_frame(8, 8, 0, f, f == 0);
        push_expected();
        wait_res("t1");
        chk("t1_busy_cycles", n_busy - b0, RING_N);
        read_one(0, d);
        chk("t1_entry0_rc", d[RES_W-1:RES_W-20], {10'd6, 10'd6});
        read_one(15, d);
        chk("t1_entry15_rc", d[RES_W-1:RES_W-20], {10'd10, 10'd10});
        chk("t1_entry15_meanvar", d[23:0], {8'd100, 16'd0});
        read_check("t1");
        do_ack("t1");

        // 2: alternating 10/20 -> mean 15, var 25
        for (int f = 0; f < 4; f++) drive_frame(8, 8, 1, f, f == 0);
        push_expected();
        wait_res("t2");
        read_one(3, d);
        chk("t2_meanvar", d[23:0], {8'd15, 16'd25});
        read_check("t2");
        do_ack("t2");
        read_one(0, d);
        chk("t2_rd_hold", d, last_exp);

        // 3: star moves at the fourth frame, restarting the batch
        b0 = n_busy;
        for (int f = 0; f < 3; f++) drive_frame(8, 8, 2, f, f == 0);
        drive_frame(7, 8, 2, 3, 1'b1);
        chk("t3_no_result", res_valid, 0);
        chk("t3_no_busy", n_busy - b0, 0);
        for (int f = 4; f < 7; f++) drive_frame(7, 8, 2, f, 1'b0);
        push_expected();
        wait_res("t3");
        read_check("t3");
        do_ack("t3");

        // 4: clipped ring near the top edge
        d0 = n_drop;
        for (int f = 0; f < 4; f++) drive_frame(1, 8, 2, f, f == 0);
        chk("t4_drops", n_drop - d0, 4);
        chk("t4_no_result", res_valid, 0);

        // 5: second batch while the buffer is held
        for (int f = 0; f < 4; f++) drive_frame(8, 8, 3, f, f == 0);
        push_expected();
        wait_res("t5");
        o0 = n_ovr;
        b0 = n_busy;
        for (int f = 0; f < 4; f++) drive_frame(8, 8, 4, f + 10, f == 0);
        chk("t5_overrun", n_ovr - o0, 1);
        chk("t5_no_busy", n_busy - b0, 0);
        chk("t5_still_valid", res_valid, 1);
        read_check("t5");
        do_ack("t5");

        // 6: asynchronous reset mid-frame, then a clean batch
        drive_frame(8, 8, 5, 0, 1'b1);
        drive_frame(8, 8, 5, 1, 1'b0);
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        vs = 1'b0;
        for (int i = 0; i < 100; i++) begin
            pix_valid = 1'b1;
            din = 8'(i);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_reset_outs", {res_valid, frame_drop, overrun, busy, rd_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int f = 0; f < 4; f++) drive_frame(8, 8, 6, f, f == 0);
        push_expected();
        wait_res("t6");
        read_check("t6");
        do_ack("t6");

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ring_stat_accum.md
Name: ring_stat_accum

Overview:
Parametrised successor to the star-ring FPN statistics block. For a tracked star centroid, it collects every pixel on the square ring of Chebyshev radius HALF around the centroid. Over 2^LOG2_FRAMES consecutive frames with a stationary star, it accumulates per-pixel sum and sum-of-squares, then computes the per-pixel mean and true variance using shifts instead of dividers. Results are held in an internal result buffer that the downstream FPN correction stage reads with a valid/ack handshake.

Parameters:
PIX_W, 8, pixel bit width
COORD_W, 10, row/column coordinate width
WIDTH, 1024, pixels per line
HEIGHT, 1024, lines per frame
HALF, 3, ring radius; RING_N = 8*HALF ring pixels
LOG2_FRAMES, 3, frames per batch = 2^LOG2_FRAMES
IDX_W, 5, result address width; must satisfy 2^IDX_W >= RING_N

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  clock enable; all state holds while low
vs  in  1  vertical sync; a rising edge marks frame start
pix_valid  in  1  din valid; one pixel per high cycle, raster order
din  in  PIX_W  pixel value
star_valid  in  1  centroid valid
star_x  in  COORD_W  centroid row
star_y  in  COORD_W  centroid column
rd_en  in  1  result read strobe
rd_addr  in  IDX_W  ring index to read
rd_data  out  2*COORD_W+3*PIX_W  {row, col, mean[PIX_W], var[2*PIX_W]}
res_valid  out  1  result buffer holds a complete batch
res_ack  in  1  consumer releases the result buffer
frame_drop  out  1  one-cycle pulse: frame rejected
overrun  out  1  one-cycle pulse: batch discarded because the buffer was still held
busy  out  1  high in COMPUTE

Behaviour:
- Reset: all outputs 0. States, counters and accumulators cleared; batch frame count = 0.
- Raster counters: on each vs rising edge (detected via a registered vs), row and col reset to 0. Each pix_valid advances col; at col==WIDTH-1, col wraps to 0 and row increments. The frame ends on the pixel at row HEIGHT-1, col WIDTH-1.
- Star latch: at each vs rising edge, (star_x, star_y, star_valid) is sampled.
  - If star_valid==0, the frame is skipped and the batch count is reset.
  - If the sampled position differs from the batch position, the batch count is reset and the new position is latched. This frame becomes frame 0.
- Ring membership: a pixel is on the ring iff max(|row-sx|, |col-sy|) == HALF. Ring index is the hit count within the frame, in raster order.
  - For HALF=3: top row is idx 0-6, the middle rows are idx 7-16 as left/right pairs, and the bottom row is idx 17-23.
- Accumulate: on a ring hit, sum[idx] and sq[idx] are updated.
  - Frame 0: sum[idx] = din, sq[idx] = din*din, and {row, col} is stored.
  - Later frames: sum[idx] += din, sq[idx] += din*din.
  - sum width is PIX_W+LOG2_FRAMES; sq width is 2*PIX_W+LOG2_FRAMES. Neither can overflow.
- Frame end: if the hit count != RING_N (ring clipped at the image edge), frame_drop pulses and the batch count is reset. Otherwise the batch count increments.
  - When the count reaches 2^LOG2_FRAMES and res_valid==0, the block enters COMPUTE.
  - When the count reaches 2^LOG2_FRAMES and res_valid==1, overrun pulses and the batch resets.
- States:
  - IDLE: no valid batch position.
  - ACCUM: batch in progress.
  - COMPUTE: entered on a completed batch; exits to ACCUM with count 0.
  - READY: tracked by the res_valid flag, independent of the other states.
- COMPUTE: one ring index per cycle, RING_N cycles, busy=1.
  - mean = sum>>LOG2_FRAMES (truncate).
  - msq = sq>>LOG2_FRAMES.
  - var = msq - mean*mean, saturating at 0 (mathematically non-negative).
  - Each entry is written to the result buffer.
  - res_valid is set on the cycle after the last write.
- pix_valid during COMPUTE: the pixels are ignored, frame_drop pulses once, and the batch resets after COMPUTE.
- Read port: rd_data is registered with 1-cycle latency after rd_en. Reads are legal only while res_valid==1; otherwise rd_data holds its last value.
- res_ack while res_valid==1 clears res_valid on the next cycle. res_ack while res_valid==0 is ignored.
- Simultaneous vs edge and last-pixel on the same cycle: frame-end processing happens first, then the new frame starts.
- Asynchronous reset mid-COMPUTE or mid-frame discards everything. The next vs starts fresh.

Test Plan:
Common setup: WIDTH=HEIGHT=16, HALF=2 (RING_N=16), LOG2_FRAMES=2, star (8,8) unless stated.
1. Constant din=100 for 4 frames -> res_valid rises after 16 busy cycles; every entry has mean=100 and var=0; entry 0 is {6,6}; entry 15 is {10,10}.
2. Ring pixels alternating 10,20,10,20 by frame -> mean=15, var=250-225=25 for all 16 entries.
3. Star moves to (7,8) at the vs of frame 3 -> no result after frame 4; res_valid rises only after 4 frames at (7,8).
4. Star at (1,8) -> the ring is clipped, frame_drop pulses every frame, and res_valid stays 0.
5. Withhold res_ack across a second full batch -> overrun pulses once and the buffer data is unchanged. Then res_ack=1 -> res_valid=0 next cycle.
6. Assert rst during frame 2 -> all outputs go to 0; the next 4 clean frames yield a correct result.
